// File: rtl/mchan_burst_splitter_pkg.sv
// rtl/mchan_burst_splitter_pkg.sv - shared cluster config types for the MCHAN burst splitter
// Contents:
//   mchan_opc_e    transfer direction (0 = TCDM->ext write, 1 = ext->TCDM read)
//   burst_desc_t   per-burst control fields (AXI len, opcode, last-of-command)
//   split_state_e  splitter FSM states
//   PAGE_BYTES     AXI 4 KiB boundary a burst may never cross
package mchan_burst_splitter_pkg;

  typedef enum logic {
    OPC_WRITE = 1'b0,
    OPC_READ  = 1'b1
  } mchan_opc_e;

  typedef struct packed {
    logic [7:0] len;
    mchan_opc_e opc;
    logic       last;
  } burst_desc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/mchan_burst_size_calc.sv
// rtl/mchan_burst_size_calc.sv - combinational burst size and AXI len computation
// Ports:
//   remaining     in   bytes left in the current command (beat aligned)
//   ext_page_off  in   external address offset within its 4 KiB page
//   size          out  min(remaining, MAX_BURST_BYTES, bytes to page end)
//   burst_len     out  AXI len field, size/BEAT_BYTES - 1
module mchan_burst_size_calc
  import mchan_burst_splitter_pkg::*;
#(
  parameter int LEN_WIDTH       = 17,
  parameter int MAX_BURST_BYTES = 256,
  parameter int BEAT_BYTES      = 8,
  parameter int SZW             = 17
) (
  input  logic [LEN_WIDTH-1:0] remaining,
  input  logic [11:0]          ext_page_off,
  output logic [SZW-1:0]       size,
  output logic [7:0]           burst_len
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  logic [SZW-1:0] page_room;
  logic [SZW-1:0] max_bytes;
  logic [SZW-1:0] beats;

  always_comb begin
    page_room = SZW'(13'(PAGE_BYTES) - {1'b0, ext_page_off});
    max_bytes = SZW'(MAX_BURST_BYTES);
    size      = SZW'(remaining);
    if (max_bytes < size) size = max_bytes;
    if (page_room < size) size = page_room;
    beats     = size >> BEAT_SHIFT;
    // Wraps when size is 0 (idle); the top masks the field outside SPLIT.
    burst_len = beats[7:0] - 8'd1;
  end

endmodule

// File: rtl/mchan_burst_splitter.sv
// rtl/mchan_burst_splitter.sv - splits DMA commands into AXI-legal burst descriptors
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake (ready only in IDLE)
//   cmd_ext_addr_i, cmd_tcdm_addr_i, cmd_len_i, cmd_opc_i   command fields
//   burst_valid_o/burst_ready_i    burst descriptor handshake
//   burst_ext_addr_o, burst_tcdm_addr_o, burst_len_o, burst_opc_o, burst_last_o
//   burst_done_i                   one pulse per completed burst
//   outstanding_o                  issued-but-uncompleted bursts
//   busy_o                         command in progress or bursts outstanding
//   cmd_err_o                      pulse after accepting a misaligned command
module mchan_burst_splitter
  import mchan_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int TCDM_ADDR_WIDTH = 17,
  parameter int LEN_WIDTH       = 17,
  parameter int MAX_BURST_BYTES = 256,
  parameter int NB_OUTSND       = 8,
  parameter int BEAT_BYTES      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]        cmd_ext_addr_i,
  input  logic [TCDM_ADDR_WIDTH-1:0]   cmd_tcdm_addr_i,
  input  logic [LEN_WIDTH-1:0]         cmd_len_i,
  input  logic                         cmd_opc_i,
  output logic                         burst_valid_o,
  input  logic                         burst_ready_i,
  output logic [ADDR_WIDTH-1:0]        burst_ext_addr_o,
  output logic [TCDM_ADDR_WIDTH-1:0]   burst_tcdm_addr_o,
  output logic [7:0]                   burst_len_o,
  output logic                         burst_opc_o,
  output logic                         burst_last_o,
  input  logic                         burst_done_i,
  output logic [$clog2(NB_OUTSND):0]   outstanding_o,
  output logic                         busy_o,
  output logic                         cmd_err_o
);

  localparam int OW  = $clog2(NB_OUTSND) + 1;
  localparam int SZW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  split_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]        ext_q;
  logic [TCDM_ADDR_WIDTH-1:0]   tcdm_q;
  logic [LEN_WIDTH-1:0]         rem_q;
  mchan_opc_e                   opc_q;
  logic [OW-1:0]                outsnd_q;
  logic                         err_q;

  logic [ADDR_WIDTH-1:0]        ext_aligned;
  logic [TCDM_ADDR_WIDTH-1:0]   tcdm_aligned;
  logic [LEN_WIDTH-1:0]         len_aligned;
  logic                         misaligned;
  logic [SZW-1:0]               size;
  logic [7:0]                   calc_len;
  logic                         last_c;
  logic                         cmd_hs, burst_hs, done_eff;
  burst_desc_t                  desc;

  // Sub-beat address/length bits are ignored; the command is still accepted.
  assign ext_aligned  = cmd_ext_addr_i  & ~ADDR_WIDTH'(BEAT_BYTES - 1);
  assign tcdm_aligned = cmd_tcdm_addr_i & ~TCDM_ADDR_WIDTH'(BEAT_BYTES - 1);
  assign len_aligned  = cmd_len_i       & ~LEN_WIDTH'(BEAT_BYTES - 1);
  assign misaligned   = ((cmd_ext_addr_i  & ADDR_WIDTH'(BEAT_BYTES - 1)) != '0) ||
                        ((cmd_tcdm_addr_i & TCDM_ADDR_WIDTH'(BEAT_BYTES - 1)) != '0) ||
                        ((cmd_len_i       & LEN_WIDTH'(BEAT_BYTES - 1)) != '0);

  mchan_burst_size_calc #(
    .LEN_WIDTH       (LEN_WIDTH),
    .MAX_BURST_BYTES (MAX_BURST_BYTES),
    .BEAT_BYTES      (BEAT_BYTES),
    .SZW             (SZW)
  ) u_size_calc (
    .remaining    (rem_q),
    .ext_page_off (ext_q[11:0]),
    .size         (size),
    .burst_len    (calc_len)
  );

  assign last_c = (state_q == ST_SPLIT) && (SZW'(rem_q) == size);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    burst_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        // A length that aligns down to zero carries no data: consume and stay.
        if (cmd_valid_i && (len_aligned != '0)) state_d = ST_SPLIT;
      end
      ST_SPLIT: begin
        burst_valid_o = (outsnd_q < OW'(NB_OUTSND));
        if (burst_valid_o && burst_ready_i && last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_hs   = cmd_valid_i && cmd_ready_o;
  assign burst_hs = burst_valid_o && burst_ready_i;
  assign done_eff = burst_done_i && (outsnd_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_q    <= '0;
      tcdm_q   <= '0;
      rem_q    <= '0;
      opc_q    <= OPC_WRITE;
      outsnd_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= cmd_hs && misaligned;
      if (cmd_hs) begin
        ext_q  <= ext_aligned;
        tcdm_q <= tcdm_aligned;
        rem_q  <= len_aligned;
        opc_q  <= mchan_opc_e'(cmd_opc_i);
      end else if (burst_hs) begin
        ext_q  <= ext_q + ADDR_WIDTH'(size);
        tcdm_q <= tcdm_q + TCDM_ADDR_WIDTH'(size);
        rem_q  <= rem_q - LEN_WIDTH'(size);
      end
      case ({burst_hs, done_eff})
        2'b10:   outsnd_q <= outsnd_q + OW'(1);
        2'b01:   outsnd_q <= outsnd_q - OW'(1);
        default: outsnd_q <= outsnd_q;
      endcase
    end
  end

  always_comb begin
    desc      = '0;
    desc.len  = (state_q == ST_SPLIT) ? calc_len : 8'd0;
    desc.opc  = opc_q;
    desc.last = last_c;
  end

  assign burst_ext_addr_o  = ext_q;
  assign burst_tcdm_addr_o = tcdm_q;
  assign burst_len_o       = desc.len;
  assign burst_opc_o       = desc.opc;
  assign burst_last_o      = desc.last;
  assign outstanding_o     = outsnd_q;
  assign busy_o            = (state_q == ST_SPLIT) || (outsnd_q != '0);
  assign cmd_err_o         = err_q;

endmodule

// File: tb/tb_mchan_burst_splitter.sv
// tb/tb_mchan_burst_splitter.sv - directed self-checking bench for mchan_burst_splitter
module tb_mchan_burst_splitter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_ext_addr_i;
  logic [16:0] cmd_tcdm_addr_i;
  logic [16:0] cmd_len_i;
  logic        cmd_opc_i;
  logic        burst_valid_o;
  logic        burst_ready_i;
  logic [31:0] burst_ext_addr_o;
  logic [16:0] burst_tcdm_addr_o;
  logic [7:0]  burst_len_o;
  logic        burst_opc_o;
  logic        burst_last_o;
  logic        burst_done_i;
  logic [3:0]  outstanding_o;
  logic        busy_o;
  logic        cmd_err_o;

  int checks = 0;
  int errors = 0;

  mchan_burst_splitter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_ext_addr_i    (cmd_ext_addr_i),
    .cmd_tcdm_addr_i   (cmd_tcdm_addr_i),
    .cmd_len_i         (cmd_len_i),
    .cmd_opc_i         (cmd_opc_i),
    .burst_valid_o     (burst_valid_o),
    .burst_ready_i     (burst_ready_i),
    .burst_ext_addr_o  (burst_ext_addr_o),
    .burst_tcdm_addr_o (burst_tcdm_addr_o),
    .burst_len_o       (burst_len_o),
    .burst_opc_o       (burst_opc_o),
    .burst_last_o      (burst_last_o),
    .burst_done_i      (burst_done_i),
    .outstanding_o     (outstanding_o),
    .busy_o            (busy_o),
    .cmd_err_o         (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command for a single cycle starting at a falling edge.
  task automatic send_cmd(input logic [31:0] ext, input logic [16:0] tcdm,
                          input logic [16:0] len, input logic opc, input logic exp_err);
    chk("cmd_ready_before_send", cmd_ready_o, 1'b1);
    cmd_valid_i     = 1'b1;
    cmd_ext_addr_i  = ext;
    cmd_tcdm_addr_i = tcdm;
    cmd_len_i       = len;
    cmd_opc_i       = opc;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("cmd_err", cmd_err_o, exp_err);
  endtask

  // Waits (bounded) for a descriptor, checks it, then handshakes it.
  task automatic take_burst(input string tag, input logic [31:0] ext, input logic [16:0] tcdm,
                            input logic [7:0] len, input logic last, input logic opc,
                            input logic done);
    for (int i = 0; i < 20; i++) begin
      if (burst_valid_o) break;
      @(negedge clk_i);
    end
    chk({tag, "_valid"}, burst_valid_o, 1'b1);
    chk({tag, "_ext"},   burst_ext_addr_o, ext);
    chk({tag, "_tcdm"},  burst_tcdm_addr_o, tcdm);
    chk({tag, "_len"},   burst_len_o, len);
    chk({tag, "_last"},  burst_last_o, last);
    chk({tag, "_opc"},   burst_opc_o, opc);
    burst_ready_i = 1'b1;
    burst_done_i  = done;
    @(negedge clk_i);
    burst_ready_i = 1'b0;
    burst_done_i  = 1'b0;
  endtask

  task automatic done_pulse();
    burst_done_i = 1'b1;
    @(negedge clk_i);
    burst_done_i = 1'b0;
  endtask

  initial begin
    rst_ni          = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_ext_addr_i  = '0;
    cmd_tcdm_addr_i = '0;
    cmd_len_i       = '0;
    cmd_opc_i       = 1'b0;
    burst_ready_i   = 1'b0;
    burst_done_i    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_valid", burst_valid_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 4'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", cmd_err_o, 1'b0);
    chk("rst_len", burst_len_o, 8'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1 KiB read, 4 full bursts.
    send_cmd(32'h1000_0000, 17'h00100, 17'd1024, 1'b1, 1'b0);
    chk("a_cmd_ready_split", cmd_ready_o, 1'b0);
    for (int k = 0; k < 4; k++)
      take_burst("a", 32'h1000_0000 + 32'(k) * 32'h100, 17'h00100 + 17'(k) * 17'h100,
                 8'd31, (k == 3), 1'b1, 1'b0);
    chk("a_idle_ready", cmd_ready_o, 1'b1);
    chk("a_outstanding", outstanding_o, 4'd4);
    chk("a_busy", busy_o, 1'b1);
    repeat (4) done_pulse();
    chk("a_outstanding_clear", outstanding_o, 4'd0);
    chk("a_busy_clear", busy_o, 1'b0);

    // 4 KiB boundary split: 64 bytes, then 192 bytes.
    send_cmd(32'h1000_0FC0, 17'h00200, 17'd256, 1'b0, 1'b0);
    take_burst("b0", 32'h1000_0FC0, 17'h00200, 8'd7,  1'b0, 1'b0, 1'b0);
    take_burst("b1", 32'h1000_1000, 17'h00240, 8'd23, 1'b1, 1'b0, 1'b0);
    chk("b_outstanding", outstanding_o, 4'd2);
    repeat (2) done_pulse();
    chk("b_outstanding_clear", outstanding_o, 4'd0);

    // Outstanding limit: 8 bursts, stall, one done releases the 9th.
    send_cmd(32'h0000_0000, 17'h00000, 17'd4096, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      take_burst("c", 32'(k) * 32'h100, 17'(k) * 17'h100, 8'd31, 1'b0, 1'b1, 1'b0);
    chk("c_stall_valid", burst_valid_o, 1'b0);
    chk("c_stall_outstanding", outstanding_o, 4'd8);
    repeat (3) @(negedge clk_i);
    chk("c_stall_valid_hold", burst_valid_o, 1'b0);
    done_pulse();
    chk("c_release_outstanding", outstanding_o, 4'd7);
    chk("c_release_valid", burst_valid_o, 1'b1);
    // Each remaining handshake coincides with a done: count must not move.
    for (int k = 8; k < 16; k++)
      take_burst("c", 32'(k) * 32'h100, 17'(k) * 17'h100, 8'd31, (k == 15), 1'b1, 1'b1);
    chk("c_simul_outstanding", outstanding_o, 4'd7);
    repeat (7) done_pulse();
    chk("c_outstanding_zero", outstanding_o, 4'd0);
    done_pulse();
    chk("c_done_at_zero", outstanding_o, 4'd0);

    // Backpressure stability and TCDM wrap.
    send_cmd(32'h2000_0000, 17'h1FF00, 17'd512, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("d_hold_valid", burst_valid_o, 1'b1);
      chk("d_hold_ext", burst_ext_addr_o, 32'h2000_0000);
      chk("d_hold_tcdm", burst_tcdm_addr_o, 17'h1FF00);
      chk("d_hold_len", burst_len_o, 8'd31);
      chk("d_hold_last", burst_last_o, 1'b0);
      @(negedge clk_i);
    end
    take_burst("d0", 32'h2000_0000, 17'h1FF00, 8'd31, 1'b0, 1'b0, 1'b0);
    take_burst("d1", 32'h2000_0100, 17'h00000, 8'd31, 1'b1, 1'b0, 1'b0);

    // Single-beat command accepted while bursts are outstanding.
    chk("e_outstanding_nonzero", outstanding_o, 4'd2);
    send_cmd(32'h3000_0000, 17'h00010, 17'd8, 1'b1, 1'b0);
    take_burst("e", 32'h3000_0000, 17'h00010, 8'd0, 1'b1, 1'b1, 1'b0);

    // Zero-length command: consumed, no burst.
    send_cmd(32'h3000_1000, 17'h00020, 17'd0, 1'b0, 1'b0);
    chk("z_valid", burst_valid_o, 1'b0);
    chk("z_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i);
    chk("z_valid_later", burst_valid_o, 1'b0);
    chk("z_outstanding", outstanding_o, 4'd3);

    // Misaligned command: low bits dropped, error pulses once.
    send_cmd(32'h4000_0003, 17'h00005, 17'd20, 1'b0, 1'b1);
    take_burst("m", 32'h4000_0000, 17'h00000, 8'd1, 1'b1, 1'b0, 1'b0);
    chk("m_err_cleared", cmd_err_o, 1'b0);
    chk("m_outstanding", outstanding_o, 4'd4);

    // Reset mid-command after 2 of 4 bursts.
    send_cmd(32'h5000_0000, 17'h00000, 17'd1024, 1'b1, 1'b0);
    take_burst("r", 32'h5000_0000, 17'h00000, 8'd31, 1'b0, 1'b1, 1'b0);
    take_burst("r", 32'h5000_0100, 17'h00100, 8'd31, 1'b0, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("r_valid", burst_valid_o, 1'b0);
    chk("r_outstanding", outstanding_o, 4'd0);
    chk("r_ready", cmd_ready_o, 1'b1);
    chk("r_busy", busy_o, 1'b0);
    chk("r_ext", burst_ext_addr_o, 32'h0);
    chk("r_tcdm", burst_tcdm_addr_o, 17'h0);
    chk("r_len", burst_len_o, 8'd0);
    chk("r_last", burst_last_o, 1'b0);
    chk("r_opc", burst_opc_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_cmd(32'h6000_0F00, 17'h00040, 17'd512, 1'b0, 1'b0);
    take_burst("p0", 32'h6000_0F00, 17'h00040, 8'd31, 1'b0, 1'b0, 1'b0);
    take_burst("p1", 32'h6000_1000, 17'h00140, 8'd31, 1'b1, 1'b0, 1'b0);
    chk("p_outstanding", outstanding_o, 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
